// File: rtl/alu_share_pkg.sv
// Shared types and constants for the ALU-sharing arbiter.
// Contents: op_e opcode encoding, state_e controller states, OP_W opcode width.
package alu_share_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_XNB  = 3'd1,
    OP_XNOR = 3'd2,
    OP_SUB  = 3'd3,
    OP_MUL  = 3'd4,
    OP_ABSD = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between N_REQ requesters and the shared ALU.
// Signals:
//   req_valid/req_ready  per-requester handshake (N_REQ bits each)
//   req_op/req_a/req_b   per-requester op code and operands, slice i per requester
//   rsp_valid/rsp_ready  single response handshake
//   rsp_data/rsp_flag    result and borrow/overflow/illegal indicator
//   rsp_id               index of the requester that issued the op
// Modports: master = requester/consumer side, slave = arbiter side.
interface alu_share_arbiter_if
  import alu_share_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 4
);
  localparam int unsigned IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0]      req_ready;
  logic [OP_W*N_REQ-1:0] req_op;
  logic [W*N_REQ-1:0]    req_a;
  logic [W*N_REQ-1:0]    req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [W-1:0]          rsp_data;
  logic                  rsp_flag;
  logic [IDW-1:0]        rsp_id;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_flag, rsp_id
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_flag, rsp_id
  );

endinterface

// File: rtl/alu_share_arbiter_rr_grant.sv
// Round-robin grant: picks the first asserted request at or after the pointer,
// wrapping around. Purely combinational.
// Ports:
//   i_req   request vector
//   i_ptr   index with highest priority this cycle
//   o_grant one-hot grant (zero when no request)
//   o_idx   encoded index of the granted requester
module rr_grant #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IDW  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDW-1:0]   i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDW-1:0]   o_idx
);

  logic [IDW:0] w_j;
  logic         w_found;

  // Scan candidates in priority order starting at the pointer.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      w_j = {1'b0, i_ptr} + (IDW+1)'(k);
      if (w_j >= (IDW+1)'(N_REQ)) w_j = w_j - (IDW+1)'(N_REQ);
      if (!w_found && i_req[w_j[IDW-1:0]]) begin
        w_found                = 1'b1;
        o_grant[w_j[IDW-1:0]]  = 1'b1;
        o_idx                  = w_j[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// One W-bit ALU shared among N_REQ requesters with round-robin arbitration.
// Ops: AND, XNB (a^~b), XNOR, SUB, MUL (shift-add, W cycles), ABSD; 6/7 illegal.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    alu_share_arbiter_if slave modport (request/response channels)
//   op_count  (only with ALU_SHARE_ARBITER_STATS_EN) 8-bit saturating
//             completed-response counter per requester, slice i = [8i+7:8i]
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 4
) (
  input  logic clk,
  input  logic rst_n,
  alu_share_arbiter_if.slave bus
`ifdef ALU_SHARE_ARBITER_STATS_EN
  ,
  output logic [N_REQ*8-1:0] op_count
`endif
);

  localparam int unsigned IDW = $clog2(N_REQ);
  localparam int unsigned CW  = $clog2(W);

  state_e           r_state, w_state_nxt;
  logic [N_REQ-1:0] w_grant;
  logic [IDW-1:0]   w_gidx;
  logic [IDW-1:0]   r_ptr, r_id;
  logic [OP_W-1:0]  r_op, w_op_in;
  logic [W-1:0]     r_a, r_b, w_a_in, w_b_in;
  logic [2*W-1:0]   r_mcand, r_acc, w_acc_nxt;
  logic [CW-1:0]    r_cnt;
  logic [W-1:0]     r_data, w_alu_data;
  logic             r_flag, w_alu_flag;
  logic             w_accept, w_rsp_hs, w_is_mul, w_mul_last;

  rr_grant #(.N_REQ(N_REQ)) u_rr (
    .i_req   (bus.req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx)
  );

  assign w_op_in    = bus.req_op[w_gidx*OP_W +: OP_W];
  assign w_a_in     = bus.req_a[w_gidx*W +: W];
  assign w_b_in     = bus.req_b[w_gidx*W +: W];
  assign w_accept   = rst_n && (r_state == IDLE) && (|w_grant);
  assign w_rsp_hs   = (r_state == DONE) && bus.rsp_ready;
  assign w_is_mul   = (r_op == OP_MUL);
  assign w_mul_last = (r_cnt == CW'(W-1));
  // r_b doubles as the multiplier shift register; its LSB gates each partial product.
  assign w_acc_nxt  = r_acc + (r_b[0] ? r_mcand : '0);

  // Single-cycle ALU ops on the latched operands.
  always_comb begin
    w_alu_data = '0;
    w_alu_flag = 1'b0;
    case (r_op)
      OP_AND:  w_alu_data = r_a & r_b;
      OP_XNB:  w_alu_data = r_a ^ ~r_b;
      OP_XNOR: w_alu_data = r_a ~^ r_b;
      OP_SUB: begin
        w_alu_data = r_a - r_b;
        w_alu_flag = (r_a < r_b);
      end
      OP_ABSD: begin
        w_alu_data = (r_a > r_b) ? (r_a - r_b) : (r_b - r_a);
        w_alu_flag = (r_a < r_b);
      end
      OP_MUL:  w_alu_data = '0;
      default: w_alu_flag = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = EXEC;
      EXEC:    if (!w_is_mul || w_mul_last) w_state_nxt = DONE;
      DONE:    if (bus.rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state; ready is held low while reset is applied.
  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = 1'b0;
    if (rst_n && (r_state == IDLE)) bus.req_ready = w_grant;
    if (r_state == DONE)            bus.rsp_valid = 1'b1;
  end

  assign bus.rsp_data = r_data;
  assign bus.rsp_flag = r_flag;
  assign bus.rsp_id   = r_id;

  // Operand capture, datapath sequencing and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_id    <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_mcand <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_flag  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op    <= w_op_in;
        r_a     <= w_a_in;
        r_b     <= w_b_in;
        r_id    <= w_gidx;
        r_mcand <= {W'(0), w_a_in};
        r_acc   <= '0;
        r_cnt   <= '0;
      end
      if (r_state == EXEC) begin
        if (w_is_mul) begin
          r_acc   <= w_acc_nxt;
          r_mcand <= r_mcand << 1;
          r_b     <= r_b >> 1;
          r_cnt   <= r_cnt + CW'(1);
          if (w_mul_last) begin
            r_data <= w_acc_nxt[W-1:0];
            r_flag <= |w_acc_nxt[2*W-1:W];
          end
        end else begin
          r_data <= w_alu_data;
          r_flag <= w_alu_flag;
        end
      end
      if (w_rsp_hs) r_ptr <= (r_id == IDW'(N_REQ-1)) ? '0 : r_id + IDW'(1);
    end
  end

`ifdef ALU_SHARE_ARBITER_STATS_EN
  logic [7:0] r_op_cnt [N_REQ];

  // Per-requester completed-response counters, saturating at 255.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_REQ); i++) r_op_cnt[i] <= '0;
    end else if (w_rsp_hs && (r_op_cnt[r_id] != 8'hFF)) begin
      r_op_cnt[r_id] <= r_op_cnt[r_id] + 8'd1;
    end
  end

  always_comb begin
    op_count = '0;
    for (int i = 0; i < int'(N_REQ); i++) op_count[i*8 +: 8] = r_op_cnt[i];
  end
`endif

endmodule
